spi_int_ctrl: RTL and testbench

//  Interrupt controller for the SPI slave peripheral. Collects NUM_SRC raw event lines

---
 rtl/spi_int_pkg.sv | 17 +
 rtl/spi_int_src.sv | 36 +++
 rtl/spi_int_ctrl.sv | 96 +++++++++
 tb/tb_spi_int_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_int_pkg.sv
// Shared types and constants for the SPI slave interrupt controller.
package spi_int_pkg;

   localparam int NUM_SRC_DEF = 4;

   localparam int SRC_TXE  = 0;
   localparam int SRC_RXF  = 1;
   localparam int SRC_OVR  = 2;
   localparam int SRC_DONE = 3;

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      GAP
   } int_state_e;

endpackage

// File: rtl/spi_int_src.sv
// One interrupt source: rising-edge detect, sticky flag and sticky overflow.
module spi_int_src (
   input  logic pclk,
   input  logic preset_n,
   input  logic evt,
   input  logic en,
   input  logic clr,
   output logic fl,
   output logic ovf
);

   logic src_q;
   logic rise;

   assign rise = evt & ~src_q;

   // A new event wins over a same-cycle clear so it is never dropped
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         src_q <= 1'b0;
         fl    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         src_q <= evt;
         if (rise & en) begin
            fl <= 1'b1;
            if (fl & ~clr)
               ovf <= 1'b1;
         end else if (clr) begin
            fl  <= 1'b0;
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/spi_int_ctrl.sv
// SPI slave interrupt controller: per-source flags, mask, priority id
// and an irq sequencer that enforces a minimum low gap.
module spi_int_ctrl
   import spi_int_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int GAP_CYC = 2,
   localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   localparam int GCW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1
) (
   input  logic               pclk,
   input  logic               preset_n,
   input  logic [NUM_SRC-1:0] src_evt,
   input  logic [NUM_SRC-1:0] int_en,
   input  logic [NUM_SRC-1:0] int_msk,
   input  logic [NUM_SRC-1:0] int_clr,
   output logic [NUM_SRC-1:0] int_fl,
   output logic [NUM_SRC-1:0] int_ovf,
   output logic               irq,
   output logic [IDW-1:0]     irq_id
);

   localparam int GAP_EFF = (GAP_CYC > 0) ? GAP_CYC : 1;
   localparam logic [GCW-1:0] GLOAD = GCW'(GAP_EFF - 1);

   int_state_e         state;
   int_state_e         state_nxt;
   logic [GCW-1:0]     gcnt;
   logic [GCW-1:0]     gcnt_nxt;
   logic [NUM_SRC-1:0] pending;
   logic               any_pend;
   logic [IDW-1:0]     enc;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      spi_int_src u_src (
         .pclk     (pclk),
         .preset_n (preset_n),
         .evt      (src_evt[i]),
         .en       (int_en[i]),
         .clr      (int_clr[i]),
         .fl       (int_fl[i]),
         .ovf      (int_ovf[i])
      );
   end

   assign pending  = int_fl & ~int_msk;
   assign any_pend = |pending;

   // Scan high to low so the lowest pending index wins
   always_comb begin
      enc = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (pending[i])
            enc = IDW'(i);
   end

   always_comb begin
      state_nxt = state;
      gcnt_nxt  = gcnt;
      unique case (state)
         IDLE: begin
            if (any_pend)
               state_nxt = ASSERT;
         end
         ASSERT: begin
            if (!any_pend) begin
               state_nxt = GAP;
               gcnt_nxt  = GLOAD;
            end
         end
         GAP: begin
            if (gcnt == '0)
               state_nxt = any_pend ? ASSERT : IDLE;
            else
               gcnt_nxt = gcnt - GCW'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state  <= IDLE;
         gcnt   <= '0;
         irq    <= 1'b0;
         irq_id <= '0;
      end else begin
         state <= state_nxt;
         gcnt  <= gcnt_nxt;
         irq   <= (state_nxt == ASSERT);
         if (any_pend)
            irq_id <= enc;
      end
   end

endmodule

// File: tb/tb_spi_int_ctrl.sv
// Directed bench for spi_int_ctrl with a scoreboard of expected
// post-edge output values.
module tb_spi_int_ctrl;
   import spi_int_pkg::*;

   logic       pclk;
   logic       preset_n;
   logic [3:0] src_evt;
   logic [3:0] int_en;
   logic [3:0] int_msk;
   logic [3:0] int_clr;
   logic [3:0] int_fl;
   logic [3:0] int_ovf;
   logic       irq;
   logic [1:0] irq_id;

   typedef struct {
      string      tag;
      logic [3:0] fl;
      logic [3:0] ovf;
      logic       irq;
      logic [1:0] id;
   } exp_t;

   exp_t q[$];

   int checks = 0;
   int errors = 0;

   logic [3:0] efl;
   logic [3:0] eovf;
   logic       eirq;
   logic [1:0] eid;

   spi_int_ctrl #(
      .NUM_SRC (4),
      .GAP_CYC (3)
   ) dut (
      .pclk     (pclk),
      .preset_n (preset_n),
      .src_evt  (src_evt),
      .int_en   (int_en),
      .int_msk  (int_msk),
      .int_clr  (int_clr),
      .int_fl   (int_fl),
      .int_ovf  (int_ovf),
      .irq      (irq),
      .irq_id   (irq_id)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic cyc(input string tag);
      exp_t e;
      e.tag = tag;
      e.fl  = efl;
      e.ovf = eovf;
      e.irq = eirq;
      e.id  = eid;
      q.push_back(e);
      @(posedge pclk);
      #1;
      e = q.pop_front();
      checks++;
      assert (int_fl === e.fl) else begin
         errors++;
         $error("FAIL %s int_fl observed=%b expected=%b", e.tag, int_fl, e.fl);
      end
      checks++;
      assert (int_ovf === e.ovf) else begin
         errors++;
         $error("FAIL %s int_ovf observed=%b expected=%b", e.tag, int_ovf, e.ovf);
      end
      checks++;
      assert (irq === e.irq) else begin
         errors++;
         $error("FAIL %s irq observed=%b expected=%b", e.tag, irq, e.irq);
      end
      checks++;
      assert (irq_id === e.id) else begin
         errors++;
         $error("FAIL %s irq_id observed=%0d expected=%0d", e.tag, irq_id, e.id);
      end
   endtask

   task automatic gap3(input string tag);
      for (int i = 0; i < 3; i++)
         cyc(tag);
   endtask

   initial begin
      preset_n = 1'b0;
      src_evt  = '0;
      int_en   = 4'b1111;
      int_msk  = '0;
      int_clr  = '0;
      efl  = '0;
      eovf = '0;
      eirq = 1'b0;
      eid  = '0;

      cyc("reset0");
      cyc("reset1");
      preset_n = 1'b1;
      cyc("post_reset");

      // 1: single event on src 2
      src_evt[SRC_OVR] = 1'b1;
      efl = 4'b0100;
      cyc("s1_flag");
      src_evt = '0;
      eirq = 1'b1;
      eid  = 2'd2;
      cyc("s1_irq");
      int_clr = 4'b0100;
      efl = '0;
      cyc("s1_clr");
      int_clr = '0;
      eirq = 1'b0;
      cyc("s1_fall");
      gap3("s1_gap");

      // 2: set beats simultaneous clear, no overflow
      src_evt[SRC_RXF] = 1'b1;
      efl = 4'b0010;
      cyc("s2_flag");
      src_evt = '0;
      eirq = 1'b1;
      eid  = 2'd1;
      cyc("s2_irq");
      src_evt[SRC_RXF] = 1'b1;
      int_clr = 4'b0010;
      cyc("s2_set_clr");
      src_evt = '0;
      int_clr = '0;
      cyc("s2_hold");
      int_clr = 4'b0010;
      efl = '0;
      cyc("s2_clr");
      int_clr = '0;
      eirq = 1'b0;
      cyc("s2_fall");
      gap3("s2_gap");

      // 3: overflow, then clear drops flag and overflow
      src_evt[SRC_TXE] = 1'b1;
      efl = 4'b0001;
      cyc("s3_flag");
      src_evt = '0;
      eirq = 1'b1;
      eid  = 2'd0;
      cyc("s3_irq");
      src_evt[SRC_TXE] = 1'b1;
      eovf = 4'b0001;
      cyc("s3_ovf");
      src_evt = '0;
      cyc("s3_hold");
      int_clr = 4'b0001;
      efl  = '0;
      eovf = '0;
      cyc("s3_clr");
      int_clr = '0;
      eirq = 1'b0;
      cyc("s3_fall");
      gap3("s3_gap");

      // 4: new source during the gap waits out exactly 3 low cycles
      src_evt[SRC_TXE] = 1'b1;
      efl = 4'b0001;
      cyc("s4_flag");
      src_evt = '0;
      eirq = 1'b1;
      cyc("s4_irq");
      int_clr = 4'b0001;
      efl = '0;
      cyc("s4_clr");
      int_clr = '0;
      src_evt[SRC_DONE] = 1'b1;
      efl  = 4'b1000;
      eirq = 1'b0;
      cyc("s4_gap1");
      src_evt = '0;
      eid = 2'd3;
      cyc("s4_gap2");
      cyc("s4_gap3");
      eirq = 1'b1;
      cyc("s4_reassert");
      int_clr = 4'b1000;
      efl = '0;
      cyc("s4_clr3");
      int_clr = '0;
      eirq = 1'b0;
      cyc("s4_fall");
      gap3("s4_gap");

      // 5: enable gates setting, mask gates irq only
      int_en = 4'b1101;
      src_evt[SRC_RXF] = 1'b1;
      cyc("s5_dis_evt");
      src_evt = '0;
      cyc("s5_dis_idle");
      int_en  = 4'b1111;
      int_msk = 4'b0001;
      src_evt[SRC_TXE] = 1'b1;
      efl = 4'b0001;
      cyc("s5_msk_flag");
      src_evt = '0;
      cyc("s5_msk_idle1");
      cyc("s5_msk_idle2");
      int_msk = '0;
      eirq = 1'b1;
      eid  = 2'd0;
      cyc("s5_unmask");

      // 6: reset mid-interrupt with the event line held high
      preset_n = 1'b0;
      src_evt[SRC_TXE] = 1'b1;
      efl  = '0;
      eovf = '0;
      eirq = 1'b0;
      eid  = '0;
      cyc("s6_reset");
      preset_n = 1'b1;
      efl = 4'b0001;
      cyc("s6_reflag");
      eirq = 1'b1;
      cyc("s6_irq");
      cyc("s6_once");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
